// File: rtl/lab4_g2_rx5.sv
// ============================================================================
// lab4_g2_rx5 : oversampling receiver for the 5-bit start/data/stop frame.
// Optional macro RX_MAJORITY_EN selects a 3-sample majority decision bit.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module lab4_g2_rx5 #(
  parameter int OS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rx,
  output logic [4:0] Q,
  output logic       gecerli,
  output logic       cerceve_hata,
  output logic       mesgul
);

  localparam int             C_TW   = $clog2(OS);
  localparam logic [C_TW-1:0] C_HALF = C_TW'(OS / 2 - 1);
  localparam logic [C_TW-1:0] C_LAST = C_TW'(OS - 1);

  typedef enum logic [2:0] {
    BOSTA = 3'd0,
    BASLA = 3'd1,
    VERI  = 3'd2,
    DUR   = 3'd3,
    BEKLE = 3'd4
  } state_t;

  state_t          state_q;
  logic [C_TW-1:0] tick_q;
  logic [2:0]      bit_q;
  logic [4:0]      sr_q;
  logic [4:0]      q_q;
  logic            gecerli_q;
  logic            cerceve_q;
  logic            mesgul_q;
  logic            rx_s1_q;
  logic            rx_s_q;
  logic            dec_bit;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s_q  <= rx_s1_q;
    end
  end

`ifdef RX_MAJORITY_EN
  logic [1:0] hist_q;

  // Two captured samples plus the live one form the three-sample window.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= 2'b11;
    end else if (en) begin
      hist_q <= {hist_q[0], rx_s_q};
    end
  end

  assign dec_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  assign dec_bit = rx_s_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BOSTA;
      tick_q    <= '0;
      bit_q     <= 3'd0;
      sr_q      <= 5'd0;
      q_q       <= 5'd0;
      gecerli_q <= 1'b0;
      cerceve_q <= 1'b0;
      mesgul_q  <= 1'b0;
    end else begin
      gecerli_q <= 1'b0;
      cerceve_q <= 1'b0;
      if (en) begin
        case (state_q)
          BOSTA: begin
            if (!rx_s_q) begin
              state_q  <= BASLA;
              tick_q   <= '0;
              mesgul_q <= 1'b1;
            end
          end
          BASLA: begin
            if (tick_q == C_HALF) begin
              tick_q <= '0;
              if (!dec_bit) begin
                state_q <= VERI;
                bit_q   <= 3'd0;
              end else begin
                state_q  <= BOSTA;
                mesgul_q <= 1'b0;
              end
            end else begin
              tick_q <= tick_q + C_TW'(1);
            end
          end
          VERI: begin
            if (tick_q == C_LAST) begin
              tick_q <= '0;
              for (int i = 0; i < 5; i++) begin
                if (bit_q == 3'(i)) sr_q[i] <= dec_bit;
              end
              bit_q <= bit_q + 3'd1;
              if (bit_q == 3'd4) state_q <= DUR;
            end else begin
              tick_q <= tick_q + C_TW'(1);
            end
          end
          DUR: begin
            if (tick_q == C_LAST) begin
              tick_q <= '0;
              if (dec_bit) begin
                q_q       <= sr_q;
                gecerli_q <= 1'b1;
                state_q   <= BOSTA;
                mesgul_q  <= 1'b0;
              end else begin
                cerceve_q <= 1'b1;
                state_q   <= BEKLE;
              end
            end else begin
              tick_q <= tick_q + C_TW'(1);
            end
          end
          BEKLE: begin
            // Wait for the line to recover so a stuck-low line cannot retrigger.
            if (rx_s_q) begin
              state_q  <= BOSTA;
              mesgul_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= BOSTA;
            tick_q   <= '0;
            mesgul_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Q            = q_q;
  assign gecerli      = gecerli_q;
  assign cerceve_hata = cerceve_q;
  assign mesgul       = mesgul_q;

endmodule

`default_nettype wire
